// File: rtl/regfile_2w2r.sv
// Architectural register file: NUM_REGS x WIDTH, two clocked write ports, two
// combinational read ports with optional same-cycle write bypass and hardwired r0.
module regfile_2w2r #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [WIDTH-1:0]  wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [WIDTH-1:0]  wr_data_b,
    input  logic [ADDR_W-1:0] rd_addr_0,
    output logic [WIDTH-1:0]  rd_data_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [WIDTH-1:0]  rd_data_1
);

    localparam int unsigned NUM_RD = 2;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];

    logic wr_ok_a;
    logic wr_ok_b;

    // Writes aimed at a hardwired r0 are discarded before they reach storage or bypass.
    always_comb begin
        wr_ok_a = wr_en_a;
        wr_ok_b = wr_en_b;
        if (ZERO_REG != 0) begin
            if (wr_addr_a == ADDR_W'(0)) wr_ok_a = 1'b0;
            if (wr_addr_b == ADDR_W'(0)) wr_ok_b = 1'b0;
        end
    end

    // Port B is applied last so it wins an address conflict.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok_a) regs_d[wr_addr_a] = wr_data_a;
        if (wr_ok_b) regs_d[wr_addr_b] = wr_data_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;

        assign addr = (p == 0) ? rd_addr_0 : rd_addr_1;

        // Bypass mirrors the commit priority and is ignored while reset is asserted.
        always_comb begin
            data = regs_q[addr];
            if ((BYPASS != 0) && !reset) begin
                if (wr_ok_a && (wr_addr_a == addr)) data = wr_data_a;
                if (wr_ok_b && (wr_addr_b == addr)) data = wr_data_b;
            end
            if ((ZERO_REG != 0) && (addr == ADDR_W'(0))) data = '0;
        end
    end

    assign rd_data_0 = g_rd[0].data;
    assign rd_data_1 = g_rd[1].data;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Directed bench for regfile_2w2r: default config, a no-bypass/no-zero-reg config
// sharing the same stimulus, and a narrow 8x8 instance.
module tb_regfile_2w2r;

    logic clk;
    logic reset;

    logic        wr_en_a, wr_en_b;
    logic [4:0]  wr_addr_a, wr_addr_b, rd_addr_0, rd_addr_1;
    logic [31:0] wr_data_a, wr_data_b;
    logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1;

    logic       s_wr_en_a, s_wr_en_b;
    logic [2:0] s_wr_addr_a, s_wr_addr_b, s_rd_addr_0, s_rd_addr_1;
    logic [7:0] s_wr_data_a, s_wr_data_b, s_rd0, s_rd1;

    int n_vec;
    int n_err;

    regfile_2w2r u_dut_a (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rd_addr_0(rd_addr_0), .rd_data_0(a_rd0),
        .rd_addr_1(rd_addr_1), .rd_data_1(a_rd1)
    );

    regfile_2w2r #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
        .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
        .rd_addr_0(rd_addr_0), .rd_data_0(b_rd0),
        .rd_addr_1(rd_addr_1), .rd_data_1(b_rd1)
    );

    regfile_2w2r #(.WIDTH(8), .NUM_REGS(8), .ADDR_W(3)) u_dut_s (
        .clk(clk), .reset(reset),
        .wr_en_a(s_wr_en_a), .wr_addr_a(s_wr_addr_a), .wr_data_a(s_wr_data_a),
        .wr_en_b(s_wr_en_b), .wr_addr_b(s_wr_addr_b), .wr_data_b(s_wr_data_b),
        .rd_addr_0(s_rd_addr_0), .rd_data_0(s_rd0),
        .rd_addr_1(s_rd_addr_1), .rd_data_1(s_rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic ea, input logic [4:0] aa, input logic [31:0] da,
                          input logic eb, input logic [4:0] ab, input logic [31:0] db);
        wr_en_a = ea; wr_addr_a = aa; wr_data_a = da;
        wr_en_b = eb; wr_addr_b = ab; wr_data_b = db;
    endtask

    task automatic set_swr(input logic ea, input logic [2:0] aa, input logic [7:0] da,
                           input logic eb, input logic [2:0] ab, input logic [7:0] db);
        s_wr_en_a = ea; s_wr_addr_a = aa; s_wr_data_a = da;
        s_wr_en_b = eb; s_wr_addr_b = ab; s_wr_data_b = db;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_swr(1'b0, 3'd0, 8'h0, 1'b0, 3'd0, 8'h0);
        rd_addr_0 = 5'd5; rd_addr_1 = 5'd31;
        s_rd_addr_0 = 3'd0; s_rd_addr_1 = 3'd7;

        // Reset state
        tick();
        reset = 1'b0;
        #1;
        check("rst_a_r5", a_rd0, 32'h0);
        check("rst_a_r31", a_rd1, 32'h0);
        check("rst_b_r5", b_rd0, 32'h0);
        check("rst_s_r7", 32'(s_rd1), 32'h0);

        // Reset clears a written register
        set_wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("wr_a_r5", a_rd0, 32'hDEADBEEF);
        check("wr_b_r5", b_rd0, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst2_a_r5", a_rd0, 32'h0);
        check("rst2_b_r5", b_rd0, 32'h0);

        // Both ports writing different registers in one edge
        rd_addr_0 = 5'd3; rd_addr_1 = 5'd7;
        set_wr(1'b1, 5'd3, 32'h12345678, 1'b1, 5'd7, 32'hCAFEF00D);
        #1;
        check("byp_a_r3", a_rd0, 32'h12345678);
        check("byp_a_r7", a_rd1, 32'hCAFEF00D);
        check("nobyp_b_r3", b_rd0, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("st_a_r3", a_rd0, 32'h12345678);
        check("st_a_r7", a_rd1, 32'hCAFEF00D);
        check("st_b_r3", b_rd0, 32'h12345678);
        check("st_b_r7", b_rd1, 32'hCAFEF00D);

        // Same-address conflict: port B wins, also on the bypass path
        rd_addr_0 = 5'd9; rd_addr_1 = 5'd9;
        set_wr(1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 32'h22222222);
        #1;
        check("cfl_byp_a_r9", a_rd0, 32'h22222222);
        check("cfl_nobyp_b_r9", b_rd0, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("cfl_a_rd0", a_rd0, 32'h22222222);
        check("cfl_a_rd1", a_rd1, 32'h22222222);
        check("cfl_b_rd1", b_rd1, 32'h22222222);
        rd_addr_1 = 5'd3;
        #1;
        check("hold_a_r3", a_rd1, 32'h12345678);

        // Zero register: hardwired in config A, ordinary in config B
        rd_addr_0 = 5'd0;
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
        #1;
        check("zr_byp_a_r0", a_rd0, 32'h0);
        check("zr_nobyp_b_r0", b_rd0, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("zr_a_r0", a_rd0, 32'h0);
        check("zr_b_r0", b_rd0, 32'hFFFFFFFF);

        // Port-B write to r0 must not disturb a port-A write elsewhere
        rd_addr_0 = 5'd10; rd_addr_1 = 5'd0;
        set_wr(1'b1, 5'd10, 32'h0BADF00D, 1'b1, 5'd0, 32'h77777777);
        #1;
        check("zrb_byp_a_r10", a_rd0, 32'h0BADF00D);
        check("zrb_byp_a_r0", a_rd1, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("zrb_a_r10", a_rd0, 32'h0BADF00D);
        check("zrb_a_r0", a_rd1, 32'h0);
        check("zrb_b_r10", b_rd0, 32'h0BADF00D);
        check("zrb_b_r0", b_rd1, 32'h77777777);

        // Bypass versus stored value
        set_wr(1'b1, 5'd4, 32'hAAAA0000, 1'b0, 5'd0, 32'h0);
        tick();
        rd_addr_1 = 5'd4;
        set_wr(1'b1, 5'd4, 32'h0000BBBB, 1'b0, 5'd0, 32'h0);
        #1;
        check("bp_a_r4", a_rd1, 32'h0000BBBB);
        check("bp_b_r4", b_rd1, 32'hAAAA0000);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("bp_a_r4_next", a_rd1, 32'h0000BBBB);
        check("bp_b_r4_next", b_rd1, 32'h0000BBBB);

        // Reset beats a concurrent write and suppresses bypass
        set_wr(1'b1, 5'd6, 32'h12121212, 1'b0, 5'd0, 32'h0);
        tick();
        rd_addr_0 = 5'd6; rd_addr_1 = 5'd7;
        reset = 1'b1;
        set_wr(1'b1, 5'd6, 32'h55555555, 1'b1, 5'd7, 32'h66666666);
        #1;
        check("rw_byp_a_r6", a_rd0, 32'h12121212);
        check("rw_byp_a_r7", a_rd1, 32'hCAFEF00D);
        check("rw_nobyp_b_r6", b_rd0, 32'h12121212);
        tick();
        reset = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rw_a_r6", a_rd0, 32'h0);
        check("rw_a_r7", a_rd1, 32'h0);
        check("rw_b_r6", b_rd0, 32'h0);

        // Narrow 8x8 instance
        s_rd_addr_0 = 3'd6; s_rd_addr_1 = 3'd7;
        set_swr(1'b1, 3'd6, 8'hA5, 1'b1, 3'd7, 8'h3C);
        tick();
        set_swr(1'b1, 3'd7, 8'h81, 1'b1, 3'd7, 8'hFE);
        #1;
        check("s_st_r6", 32'(s_rd0), 32'h000000A5);
        check("s_cfl_byp_r7", 32'(s_rd1), 32'h000000FE);
        tick();
        set_swr(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h0);
        s_rd_addr_0 = 3'd0;
        #1;
        check("s_cfl_r7", 32'(s_rd1), 32'h000000FE);
        check("s_zr_byp_r0", 32'(s_rd0), 32'h0);
        tick();
        s_rd_addr_0 = 3'd6;
        reset = 1'b1;
        set_swr(1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 8'h0);
        #1;
        check("s_rw_byp_r6", 32'(s_rd0), 32'h000000A5);
        tick();
        reset = 1'b0;
        set_swr(1'b0, 3'd0, 8'h0, 1'b0, 3'd0, 8'h0);
        #1;
        check("s_rw_r6", 32'(s_rd0), 32'h0);
        check("s_rw_r7", 32'(s_rd1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_2w2r.md
Name: regfile_2w2r

Overview:
- Parametrised multi-register storage block; the successor to the single 32-bit enable/reset register.
- Holds NUM_REGS words of WIDTH bits.
- Two independent write ports, committed at the clock edge; two asynchronous read ports with optional same-cycle write-to-read bypass.
- Sits between decode and execute as the architectural register file; register 0 can be hardwired to zero.

Parameters:
- WIDTH, 32, bits per register.
- NUM_REGS, 32, number of registers; must be a power of two, >= 2.
- ADDR_W, 5, address width; must equal log2(NUM_REGS).
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = reads return data being written this cycle; 0 = reads return stored contents only.

Ports:
- clk  input  1  clock, rising-edge active
- reset  input  1  synchronous, active-high; clears all registers at the next rising clk edge
- wr_en_a  input  1  write enable, port A
- wr_addr_a  input  ADDR_W  write address, port A
- wr_data_a  input  WIDTH  write data, port A
- wr_en_b  input  1  write enable, port B
- wr_addr_b  input  ADDR_W  write address, port B
- wr_data_b  input  WIDTH  write data, port B
- rd_addr_0  input  ADDR_W  read address, port 0
- rd_data_0  output  WIDTH  read data, port 0 (combinational)
- rd_addr_1  input  ADDR_W  read address, port 1
- rd_data_1  output  WIDTH  read data, port 1 (combinational)

Behaviour:
- One clock, clk; reset is synchronous and active-high. No asynchronous paths into state.
- Reset:
  - Rising edge with reset=1 loads every register with 0, regardless of any write enable.
  - Reset has priority over both write ports.
  - After the edge, both rd_data outputs are 0 for any address.
- Writes:
  - Rising edge with reset=0 and wr_en_x=1 stores wr_data_x into register wr_addr_x.
  - Written value is visible in stored contents from the following cycle. Registers not addressed by an enabled write hold their value.
- Write conflict: both ports enabled with wr_addr_a == wr_addr_b -> port B's data is stored, port A's is discarded. No error flag.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped on either port.
  - Reads of address 0 return 0, including on the bypass path.
  - A port-B write to 0 never overrides a port-A write elsewhere.
- Read, BYPASS=0: rd_data_n = stored[rd_addr_n], purely combinational, zero-cycle latency.
- Read, BYPASS=1: if reset=0 and an enabled write targets rd_addr_n in the current cycle, rd_data_n returns that write data; otherwise stored[rd_addr_n].
  - Bypass follows the conflict rule: port B beats port A.
  - Bypass is suppressed while reset=1; reads then show the pre-reset stored value.
  - Bypass is suppressed for address 0 when ZERO_REG=1.
- Both read ports are fully independent; reading the same address on both ports is legal and returns identical data.
- Power-up contents before the first reset are undefined (X in simulation). The bench must apply reset before checking.
- Widths: addresses are compared at full ADDR_W. No truncation or sign extension of data.

Test Plan:
- Reset then read: reset=1 for 1 edge after writing 0xDEADBEEF to r5 -> rd_data_0 at rd_addr_0=5 reads 0x00000000.
- Basic write/read: write A r3=0x12345678 and B r7=0xCAFEF00D in the same edge -> next cycle rd_addr_0=3 gives 0x12345678, rd_addr_1=7 gives 0xCAFEF00D.
- Conflict: both ports write r9, A=0x11111111, B=0x22222222 -> r9 reads 0x22222222 afterwards; with BYPASS=1, rd_addr_0=9 shows 0x22222222 in the write cycle.
- Zero register: write A r0=0xFFFFFFFF (ZERO_REG=1) -> rd_data at address 0 is 0 in the write cycle and after; with ZERO_REG=0, it reads 0xFFFFFFFF next cycle.
- Bypass vs no bypass: r4 holds 0xAAAA0000; write A r4=0x0000BBBB while rd_addr_1=4 -> BYPASS=1 gives 0x0000BBBB that cycle; BYPASS=0 gives 0xAAAA0000, then 0x0000BBBB the next cycle.
- Reset mid-write: reset=1 and wr_en_a=1 to r6=0x55555555 on the same edge -> r6 reads 0; bypass shows old r6 during that cycle. Repeat with WIDTH=8, NUM_REGS=8 parameter override.
